// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a single FIFO write side.
// Each grant allows at most BURST consecutive writes; a FIFO-full stall
// holds the grant and the burst count. Accept/write strobes are combinational
// off the registered grant so a transfer can happen every cycle.
module fifo_wr_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [WIDTH-1:0]        fifo_din,
   output logic [NREQ-1:0]         grant,
   output logic                    busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [IW-1:0]   own;
   logic [IW-1:0]   last;
   logic [CW-1:0]   cnt;

   logic            own_valid;
   logic            release_c;
   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   arb_base;

   // Write-side strobes and data steering for the current owner
   always_comb begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      own_valid  = req_valid[own];
      release_c  = 1'b0;
      if (state == GRANT) begin
         req_ready[own] = !fifo_full;
         fifo_wr_en     = own_valid && !fifo_full;
         if (fifo_wr_en) begin
            fifo_din = req_data[32'(own)*WIDTH +: WIDTH];
         end
         release_c = (fifo_wr_en && (cnt == CW'(BURST - 1))) ||
                     (!own_valid && !fifo_full);
      end
   end

   // Round-robin search starting just after the base; the base itself is
   // visited last, so it only wins when it is the sole requester
   always_comb begin
      logic [IW-1:0] jj;
      jj        = '0;
      arb_base  = (state == IDLE) ? last : own;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         jj = IW'((32'(arb_base) + k) % NREQ);
         if (req_valid[jj]) begin
            win_found = 1'b1;
            win_idx   = jj;
         end
      end
   end

   // Grant FSM: arbitration, burst counting and back-to-back re-grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         cnt   <= '0;
         own   <= '0;
         last  <= IW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state <= GRANT;
                  grant <= NREQ'(1) << win_idx;
                  own   <= win_idx;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            GRANT: begin
               if (release_c) begin
                  last <= own;
                  cnt  <= '0;
                  if (win_found) begin
                     grant <= NREQ'(1) << win_idx;
                     own   <= win_idx;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                     busy  <= 1'b0;
                  end
               end else if (fifo_wr_en) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, a FIFO stand-in and a
// transaction-level reference model of the round-robin/burst rules.
module tb_fifo_wr_arbiter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned BURST = 4;
   localparam int unsigned DEPTH = 8;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [WIDTH-1:0]      fifo_din;
   logic [NREQ-1:0]       grant;
   logic                  busy;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant      (grant),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // producer beat queues, FIFO contents, expected FIFO contents
   logic [WIDTH-1:0] pq [NREQ][$];
   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] exp_out[$];
   logic [NREQ-1:0]  wtrace[$];
   int               wcyc[$];
   int               cyc;
   int               rd_pct;

   // reference model: owner index (-1 = nobody), beats in current burst, last owner
   int m_own;
   int m_cnt;
   int m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic vbit(input logic [NREQ-1:0] v, input int i);
      return ((v >> i) & NREQ'(1)) != '0;
   endfunction

   // first valid requester after base, wrapping; base itself is checked last
   function automatic int rr(input logic [NREQ-1:0] v, input int base);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (base + k) % NREQ;
         if (vbit(v, j)) return j;
      end
      return -1;
   endfunction

   function automatic logic is_idle();
      logic e;
      e = (m_own < 0);
      for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = (pq[i].size() != 0);
         req_data[i*WIDTH +: WIDTH] = (pq[i].size() != 0) ? pq[i][0] : '0;
      end
      fifo_full = (fq.size() >= DEPTH);
   endtask

   // one clock cycle: entered and left at posedge+1
   task automatic cycle();
      logic [NREQ-1:0]  e_ready;
      logic             e_wr;
      logic [WIDTH-1:0] e_din;
      logic             s_wr;
      logic             s_rd;
      logic [WIDTH-1:0] s_din;
      logic             rel;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] ed;
      logic [NREQ-1:0]  e_g;
      drive_inputs();
      #4;
      e_ready = '0;
      e_wr    = 1'b0;
      e_din   = '0;
      if (m_own >= 0) begin
         if (!fifo_full) e_ready = NREQ'(1) << m_own;
         e_wr = vbit(req_valid, m_own) && !fifo_full;
         if (e_wr) e_din = pq[m_own][0];
      end
      chk("req_ready",  32'(req_ready),  32'(e_ready));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      chk("fifo_din",   32'(fifo_din),   32'(e_din));
      chk("inv_onehot_grant", 32'($onehot0(grant)), 32'(1));
      chk("inv_onehot_ready", 32'($onehot0(req_ready)), 32'(1));
      chk("inv_wr_not_full",  32'(fifo_wr_en && fifo_full), 32'(0));
      chk("inv_wr_eq_xfer",   32'(fifo_wr_en), 32'(|(req_valid & req_ready)));
      chk("inv_busy_grant",   32'(busy), 32'(|grant));
      s_wr  = fifo_wr_en;
      s_din = fifo_din;
      s_rd  = (32'($urandom_range(99)) < 32'(rd_pct)) && (fq.size() != 0);
      if (s_wr) begin
         wtrace.push_back(grant);
         wcyc.push_back(cyc);
      end
      if (m_own < 0) begin
         if (req_valid != '0) begin
            m_own = rr(req_valid, m_last);
            m_cnt = 0;
         end
      end else begin
         rel = (e_wr && m_cnt == BURST - 1) || (!vbit(req_valid, m_own) && !fifo_full);
         if (e_wr) begin
            void'(pq[m_own].pop_front());
            exp_out.push_back(e_din);
         end
         if (rel) begin
            m_last = m_own;
            m_own  = rr(req_valid, m_own);
            m_cnt  = 0;
         end else if (e_wr) begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_rd) begin
         d  = fq.pop_front();
         ed = (exp_out.size() != 0) ? exp_out.pop_front() : 'x;
         chk("dout", 32'(d), 32'(ed));
      end
      if (s_wr) fq.push_back(s_din);
      e_g = (m_own >= 0) ? NREQ'(1) << m_own : '0;
      chk("grant", 32'(grant), 32'(e_g));
      chk("busy",  32'(busy),  32'(m_own >= 0));
   endtask

   task automatic run_until_idle(input int budget, input string name);
      int n;
      n = 0;
      while (!is_idle() && n < budget) begin
         cycle();
         n++;
      end
      chk(name, 32'(is_idle()), 32'(1));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      rd_pct = 100;
      while (fq.size() != 0 && n < 40) begin
         cycle();
         n++;
      end
      chk(name, 32'(fq.size()), 32'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) pq[i].delete();
      fq.delete();
      exp_out.delete();
      wtrace.delete();
      wcyc.delete();
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      rd_pct    = 0;
      cyc       = 0;
      m_own     = -1;
      m_cnt     = 0;
      m_last    = NREQ - 1;
      #1;
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_busy",  32'(busy),  32'(0));
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
      chk("rst_din",   32'(fifo_din), 32'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [NREQ-1:0] valid;
      logic [NREQ-1:0] exp_grant;
   } arb_vec_t;

   arb_vec_t tbl[6];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      rst_n = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      // first grant out of reset: lowest-numbered valid requester wins
      tbl[0] = '{4'b0001, 4'b0001};
      tbl[1] = '{4'b1000, 4'b1000};
      tbl[2] = '{4'b1010, 4'b0010};
      tbl[3] = '{4'b0110, 4'b0010};
      tbl[4] = '{4'b1111, 4'b0001};
      tbl[5] = '{4'b1100, 4'b0100};
      for (int t = 0; t < 6; t++) begin
         do_reset();
         for (int i = 0; i < NREQ; i++)
            if (tbl[t].valid[i]) pq[i].push_back(WIDTH'(8'h10 + i));
         cycle();
         chk("tbl_grant", 32'(grant), 32'(tbl[t].exp_grant));
         rd_pct = 100;
         run_until_idle(60, "tbl_idle");
         drain("tbl_drain");
      end

      // single requester, three beats, readback
      do_reset();
      pq[0].push_back(8'hA0);
      pq[0].push_back(8'hA1);
      pq[0].push_back(8'hA2);
      cycle();
      chk("t1_grant", 32'(grant), 32'(4'b0001));
      run_until_idle(20, "t1_idle");
      chk("t1_writes", 32'(wtrace.size()), 32'(3));
      chk("t1_first_wr", 32'(wcyc[0]), 32'(1));
      chk("t1_consec", 32'(wcyc[2] - wcyc[0]), 32'(2));
      chk("t1_fifo_n", 32'(fq.size()), 32'(3));
      chk("t1_rd0", 32'(fq[0]), 32'(8'hA0));
      chk("t1_rd1", 32'(fq[1]), 32'(8'hA1));
      chk("t1_rd2", 32'(fq[2]), 32'(8'hA2));
      drain("t1_drain");

      // all four continuously valid: bursts of four, strict rotation, no bubble
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int b = 0; b < 5; b++) pq[i].push_back(WIDTH'($urandom));
      rd_pct = 100;
      run_until_idle(100, "t2_idle");
      chk("t2_writes", 32'(wtrace.size()), 32'(20));
      chk("t2_first_wr", 32'(wcyc[0]), 32'(1));
      chk("t2_16_in_16", 32'(wcyc[15] - wcyc[0]), 32'(15));
      for (int k = 0; k < 17; k++)
         chk("t2_order", 32'(wtrace[k]), 32'(NREQ'(1) << ((k / 4) % 4)));
      drain("t2_drain");

      // one requester, ten beats: re-grants to itself with no gap
      do_reset();
      for (int b = 0; b < 10; b++) pq[2].push_back(WIDTH'($urandom));
      rd_pct = 100;
      run_until_idle(60, "t3_idle");
      chk("t3_writes", 32'(wtrace.size()), 32'(10));
      chk("t3_consec", 32'(wcyc[9] - wcyc[0]), 32'(9));
      for (int k = 0; k < 10; k++) chk("t3_owner", 32'(wtrace[k]), 32'(4'b0100));
      drain("t3_drain");

      // FIFO fills mid-burst of requester 1, stall, then one read frees a slot
      do_reset();
      for (int b = 0; b < 6; b++) pq[0].push_back(WIDTH'(8'h40 + b));
      run_until_idle(30, "t4_pre_idle");
      for (int b = 0; b < 6; b++) pq[1].push_back(WIDTH'(8'h50 + b));
      n = 0;
      while (fq.size() < DEPTH && n < 20) begin
         cycle();
         n++;
      end
      chk("t4_full", 32'(fq.size()), 32'(DEPTH));
      chk("t4_writes", 32'(wtrace.size()), 32'(8));
      repeat (3) cycle();
      chk("t4_stalled", 32'(wtrace.size()), 32'(8));
      chk("t4_grant_held", 32'(grant), 32'(4'b0010));
      rd_pct = 100;
      cycle();
      rd_pct = 0;
      cycle();
      chk("t4_resume", 32'(wtrace.size()), 32'(9));
      chk("t4_resume_owner", 32'(wtrace[8]), 32'(4'b0010));
      rd_pct = 100;
      run_until_idle(60, "t4_idle");
      drain("t4_drain");

      // wrap-around: after requester 0 was served, 3 beats 0
      do_reset();
      pq[0].push_back(8'h01);
      rd_pct = 100;
      run_until_idle(20, "t5_pre_idle");
      wtrace.delete();
      pq[0].push_back(8'h02);
      pq[3].push_back(8'h03);
      run_until_idle(20, "t5_idle");
      chk("t5_first", 32'(wtrace[0]), 32'(4'b1000));
      chk("t5_second", 32'(wtrace[1]), 32'(4'b0001));
      drain("t5_drain");

      // asynchronous reset in the middle of a burst
      do_reset();
      for (int b = 0; b < 6; b++) pq[1].push_back(WIDTH'(8'h60 + b));
      rd_pct = 100;
      n = 0;
      while (wtrace.size() < 2 && n < 10) begin
         cycle();
         n++;
      end
      chk("t6_two_beats", 32'(wtrace.size()), 32'(2));
      drive_inputs();
      #2;
      chk("t6_pre_wr", 32'(fifo_wr_en), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("t6_grant", 32'(grant), 32'(0));
      chk("t6_busy",  32'(busy),  32'(0));
      chk("t6_wr_en", 32'(fifo_wr_en), 32'(0));
      chk("t6_ready", 32'(req_ready), 32'(0));
      do_reset();
      pq[1].push_back(8'h71);
      pq[2].push_back(8'h72);
      cycle();
      chk("t6_regrant", 32'(grant), 32'(4'b0010));
      rd_pct = 100;
      run_until_idle(30, "t6_idle");
      drain("t6_drain");

      // randomized traffic with occasional FIFO backpressure
      do_reset();
      for (int c = 0; c < 900; c++) begin
         int r;
         rd_pct = (c < 450) ? 45 : 85;
         if ($urandom_range(99) < 55) begin
            r = int'($urandom_range(NREQ - 1));
            if (pq[r].size() < 6) pq[r].push_back(WIDTH'($urandom));
         end
         cycle();
      end
      rd_pct = 100;
      run_until_idle(300, "rnd_idle");
      drain("rnd_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's `fifo` (`WIDTH`/`DEPTH` parameterised; `wr_en`/`din`/`full`) among `NREQ` producers.
- Arbitration is round-robin with bounded bursts, so no producer can monopolise the FIFO.
- Sits directly in front of the FIFO write side: its outputs drive `wr_en` and `din`, and `full` feeds back in.
- The FIFO read side is untouched.

Parameters:
- `WIDTH`, 8, data width; must match the FIFO `WIDTH`.
- `NREQ`, 4, number of requesters (2..8).
- `BURST`, 4, maximum consecutive writes per grant (1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NREQ`  per-requester data-valid.
- `req_data`  in  `NREQ*WIDTH`  requester i data in bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  `NREQ`  per-requester accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_din`  out  `WIDTH`  to FIFO `din`.
- `grant`  out  `NREQ`  registered one-hot current owner; all zero when idle.
- `busy`  out  1  high in GRANT state.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE, `grant`=0, `busy`=0, burst count=0.
  - Round-robin pointer `last`=`NREQ-1`, so requester 0 has first priority.
  - Combinational outputs follow: `req_ready`=0, `fifo_wr_en`=0, `fifo_din`=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit searching `last+1, last+2, ...` modulo `NREQ`.
  - Next cycle: state=GRANT, `grant`=onehot(winner), count=0.
  - No accept is possible in IDLE, so there is one cycle of arbitration latency from first `req_valid` to the earliest transfer.
- GRANT, owner g (combinational):
  - `req_ready[g]` = `!fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en` = `req_valid[g] & !fifo_full`.
  - `fifo_din` = `req_data[g]` when `fifo_wr_en`, else 0.
- Count increments on each write; it holds while `fifo_full` (stall with no timeout, grant retained).
- Release condition, evaluated each GRANT cycle:
  - (a) a write occurs with count == `BURST-1`, or
  - (b) `req_valid[g]`=0 and `fifo_full`=0.
  - While `fifo_full`=1, deasserting `req_valid[g]` does not release the grant.
- On release:
  - `last` <= g.
  - Re-arbitrate in the same cycle over the current `req_valid`, starting from g+1. g itself is eligible only when it is the sole requester.
  - If a winner exists: stay in GRANT with the new one-hot `grant` and count=0 (back-to-back, no bubble).
  - Otherwise: go to IDLE, `grant`=0.
- Single requester with a continuous stream: bursts of `BURST` writes with no idle gap. The grant re-issues to the same requester, and count resets.
- Producers must hold `req_valid`/`req_data` stable until accepted. The arbiter never drops or duplicates a beat.
- `fifo_din` is 0 whenever `fifo_wr_en`=0; the FIFO ignores it, but this keeps waveforms clean.
- Invariants (the bench asserts each cycle):
  - `$onehot0(grant)`.
  - `$onehot0(req_ready)`.
  - `fifo_wr_en` → `!fifo_full`.
  - `fifo_wr_en` == `|(req_valid & req_ready)`.
  - `busy` == `|grant`.
- Reset mid-burst: all state clears immediately (asynchronously). The transfer in the reset cycle does not occur. After `rst_n` rises, arbitration restarts from requester 0.

Test Plan:
- Reset, then `req_valid`=4'b0001 with data 8'hA0, A1, A2 (advance on each accept) → `grant`=0001 one cycle later; `fifo_wr_en` for 3 consecutive cycles with `fifo_din` A0, A1, A2; release on valid drop → IDLE; FIFO `dout` reads back A0, A1, A2.
- All four requesters continuously valid, `BURST`=4 → grant order 0,1,2,3,0; exactly 4 writes per grant; no idle cycle between grants; 16 writes in 16 cycles after the first grant.
- Requester 2 only, 10 beats, `BURST`=4 → writes in groups 4, 4, 2; `grant` stays 0100 throughout; IDLE after beat 10.
- Fill the FIFO (`DEPTH`=8) while requester 1 streams → `req_ready`=0 and `fifo_wr_en`=0 while `full`; count frozen at its value (e.g. 2); after one FIFO read, the write resumes with the next beat and no beat is lost or duplicated.
- Requesters 0 and 3 valid, `last`=0 → requester 3 wins first, then 0 (wrap-around of the round-robin search).
- `rst_n` pulsed low mid-burst (requester 1, count=2) → `grant`, `busy`, `fifo_wr_en`, `req_ready` go to 0 within the same cycle without waiting for a clock; after release, with requesters 1 and 2 valid, requester 1 is granted first (pointer reset).
